// File: rtl/canvas_pkg.sv
// Shared constants and types for the canvas cursor engine: button bit
// positions, 3-bit {R,G,B} colour codes and the write-request FSM state.
package canvas_pkg;
  localparam int UP    = 3;
  localparam int DOWN  = 2;
  localparam int RIGHT = 1;
  localparam int LEFT  = 0;

  localparam logic [2:0] C_BLACK   = 3'b000;
  localparam logic [2:0] C_ERASE   = 3'b000;
  localparam logic [2:0] C_BLUE    = 3'b001;
  localparam logic [2:0] C_GREEN   = 3'b010;
  localparam logic [2:0] C_CYAN    = 3'b011;
  localparam logic [2:0] C_RED     = 3'b100;
  localparam logic [2:0] C_MAGENTA = 3'b101;
  localparam logic [2:0] C_YELLOW  = 3'b110;
  localparam logic [2:0] C_WHITE   = 3'b111;

  typedef enum logic {IDLE, PEND} state_e;
endpackage

// File: rtl/canvas_btn_conditioner.sv
// One direction button: 2-FF synchroniser, counter debounce, and a step
// pulse on the debounced rising edge plus delayed auto-repeat while held.
module canvas_btn_conditioner #(
  parameter int DEBOUNCE_CYC = 16,
  parameter int REPEAT_DELAY = 64,
  parameter int REPEAT_RATE  = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic step_o
);
  localparam int DW   = $clog2(DEBOUNCE_CYC + 1);
  localparam int HMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int HW   = $clog2(HMAX + 1);

  logic [1:0]    sync_q;
  logic          deb_q, deb_d, deb_prev_q;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic          rep_q, rep_d;
  logic          edge_s, rpt_s;

  always_comb begin
    deb_d  = deb_q;
    dcnt_d = '0;
    if (sync_q[1] != deb_q) begin
      if (dcnt_q == DW'(DEBOUNCE_CYC - 1)) deb_d = sync_q[1];
      else                                 dcnt_d = dcnt_q + DW'(1);
    end

    // hcnt counts cycles since the last step; rep_q selects delay vs rate
    edge_s = deb_q & ~deb_prev_q;
    rpt_s  = deb_q & ~edge_s &
             (rep_q ? (hcnt_q == HW'(REPEAT_RATE)) : (hcnt_q == HW'(REPEAT_DELAY)));
    hcnt_d = hcnt_q + HW'(1);
    rep_d  = rep_q;
    if (!deb_q) begin
      hcnt_d = '0;
      rep_d  = 1'b0;
    end else if (rpt_s) begin
      hcnt_d = HW'(1);
      rep_d  = 1'b1;
    end
  end

  assign step_o = edge_s | rpt_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      dcnt_q     <= '0;
      hcnt_q     <= '0;
      rep_q      <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], btn_i};
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      dcnt_q     <= dcnt_d;
      hcnt_q     <= hcnt_d;
      rep_q      <= rep_d;
    end
  end
endmodule

// File: rtl/canvas_cursor_engine.sv
// Cursor position on a GRID_W x GRID_H grid driven by conditioned buttons;
// each accepted move emits one pixel-write request over valid/ready.
module canvas_cursor_engine
  import canvas_pkg::*;
#(
  parameter int GRID_W       = 16,
  parameter int GRID_H       = 16,
  parameter int DEBOUNCE_CYC = 16,
  parameter int REPEAT_DELAY = 64,
  parameter int REPEAT_RATE  = 16,
  localparam int XW = (GRID_W > 1) ? $clog2(GRID_W) : 1,
  localparam int YW = (GRID_H > 1) ? $clog2(GRID_H) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    buttons,
  input  logic [2:0]    color,
  input  logic          brush,
  input  logic          wr_ready,
  output logic          wr_valid,
  output logic [XW-1:0] wr_x,
  output logic [YW-1:0] wr_y,
  output logic [2:0]    wr_color,
  output logic [XW-1:0] cur_x,
  output logic [YW-1:0] cur_y
);
  localparam logic [XW-1:0] XMAX = XW'(GRID_W - 1);
  localparam logic [YW-1:0] YMAX = YW'(GRID_H - 1);

  logic [3:0] step;

  for (genvar i = 0; i < 4; i++) begin : g_btn
    canvas_btn_conditioner #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE (REPEAT_RATE)
    ) u_cond (
      .clk   (clk),
      .rst_n (rst_n),
      .btn_i (buttons[i]),
      .step_o(step[i])
    );
  end

  state_e        state_q, state_d;
  logic [XW-1:0] cur_x_q, cur_x_d, wr_x_q, wr_x_d, nx;
  logic [YW-1:0] cur_y_q, cur_y_d, wr_y_q, wr_y_d, ny;
  logic [2:0]    wr_color_q, wr_color_d;
  logic          move;

  always_comb begin
    nx = cur_x_q;
    if (step[RIGHT] && !step[LEFT] && cur_x_q != XMAX)   nx = cur_x_q + XW'(1);
    else if (step[LEFT] && !step[RIGHT] && cur_x_q != '0) nx = cur_x_q - XW'(1);
    // y = 0 is the top row: down increments
    ny = cur_y_q;
    if (step[DOWN] && !step[UP] && cur_y_q != YMAX)     ny = cur_y_q + YW'(1);
    else if (step[UP] && !step[DOWN] && cur_y_q != '0)  ny = cur_y_q - YW'(1);
    move = (nx != cur_x_q) || (ny != cur_y_q);

    state_d    = state_q;
    cur_x_d    = cur_x_q;
    cur_y_d    = cur_y_q;
    wr_x_d     = wr_x_q;
    wr_y_d     = wr_y_q;
    wr_color_d = wr_color_q;
    // A stalled request drops concurrent moves; a completing one may reload.
    if (move && (state_q == IDLE || wr_ready)) begin
      state_d    = PEND;
      cur_x_d    = nx;
      cur_y_d    = ny;
      wr_x_d     = nx;
      wr_y_d     = ny;
      wr_color_d = brush ? color : C_ERASE;
    end else if (state_q == PEND && wr_ready) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cur_x_q    <= XW'(GRID_W / 2);
      cur_y_q    <= YW'(GRID_H / 2);
      wr_x_q     <= '0;
      wr_y_q     <= '0;
      wr_color_q <= '0;
    end else begin
      state_q    <= state_d;
      cur_x_q    <= cur_x_d;
      cur_y_q    <= cur_y_d;
      wr_x_q     <= wr_x_d;
      wr_y_q     <= wr_y_d;
      wr_color_q <= wr_color_d;
    end
  end

  assign wr_valid = (state_q == PEND);
  assign wr_x     = wr_x_q;
  assign wr_y     = wr_y_q;
  assign wr_color = wr_color_q;
  assign cur_x    = cur_x_q;
  assign cur_y    = cur_y_q;
endmodule
